bmem_arbiter: RTL and testbench
===============================

# bmem_arbiter

Merges the instruction-cache and data-cache line-fill/writeback ports of `cpu_top` onto the single banked-memory port (`bmem_*`) that the top-level bench connects to `banked_memory`. Converts 256-bit cache-line transactions into 4-beat 64-bit bursts and reassembles read bursts into full lines. Allows one outstanding transaction at a time and arbitrates round-robin between the two caches.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width.
- `BEAT_WIDTH`, 64: banked-memory data beat width.
- `BEATS`, 4: beats per cache line; line width is `BEAT_WIDTH*BEATS` = 256.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `i_addr`  in  ADDR_WIDTH  icache line address; low 5 bits ignored.
- `i_read`  in  1  icache line-read request.
- `i_rdata`  out  256  filled line for icache.
- `i_resp`  out  1  one-cycle completion pulse for icache.
- `d_addr`  in  ADDR_WIDTH  dcache line address.
- `d_read`  in  1  dcache line-read request.
- `d_write`  in  1  dcache line-writeback request.
- `d_wdata`  in  256  dcache writeback line.
- `d_rdata`  out  256  filled line for dcache.
- `d_resp`  out  1  one-cycle completion pulse for dcache.
- `bmem_addr`  out  ADDR_WIDTH  line-aligned address (low 5 bits zero).
- `bmem_read`  out  1  read request.
- `bmem_write`  out  1  write beat valid.
- `bmem_wdata`  out  BEAT_WIDTH  write beat.
- `bmem_ready`  in  1  memory accepts the current read request or write beat.
- `bmem_raddr`  in  ADDR_WIDTH  address tag of the returning read beat.
- `bmem_rdata`  in  BEAT_WIDTH  read beat.
- `bmem_rvalid`  in  1  read beat valid.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP.
- IDLE: pick a requester from `i_read` and `d_read|d_write`.
  - If both request, the port not granted last wins.
  - `last_grant` resets to dcache, so icache wins the first tie.
  - Latch grant, aligned address, and op (read or write); clear `beat` to 0.
  - Go to RD_REQ for reads, WR_BURST for writes.
- RD_REQ: drive `bmem_read=1` and `bmem_addr`. Hold until `bmem_ready` is sampled high, then go to RD_WAIT.
- RD_WAIT: on `bmem_rvalid && bmem_raddr==latched addr`:
  - Store `bmem_rdata` into line bits `[64*beat+63 : 64*beat]`; `beat++`.
  - On the beat where `beat==3` (fourth beat), go to RESP.
  - Beats with a non-matching `raddr` are ignored.
- WR_BURST: drive `bmem_write=1`, `bmem_addr`, and `bmem_wdata = d_wdata[64*beat +: 64]`.
  - Advance `beat` only when `bmem_ready` is high.
  - When beat 3 is accepted, go to RESP.
- RESP: pulse `i_resp` or `d_resp` (granted port only) for exactly 1 cycle; update `last_grant`; return to IDLE.
- `*_rdata` is driven from the line buffer. It is valid in the RESP cycle and holds until the next read completes for that port; icache and dcache each have their own register.
- `d_read && d_write` together is illegal (assertion); treat as a write.
- Requesters must hold their request signals stable until `resp` (assertion). Requests are re-sampled only in IDLE.
- `bmem_rvalid` outside RD_WAIT is ignored (assertion warning).
- Width rules:
  - `beat` is 2 bits and never wraps within a transaction.
  - `bmem_addr = {addr[ADDR_WIDTH-1:5], 5'b0}`.

## Timing
- Reset values: all `bmem_*` outputs 0, `i_resp`/`d_resp` 0, `i_rdata`/`d_rdata` 0, state IDLE, `beat` 0.
- Reset mid-transaction (in any state): next cycle IDLE, all outputs low, partial line discarded, no resp.
- Outputs are registered or state-decoded only; there is no combinational path from cache inputs to `bmem_*`.
- Read, request sampled in IDLE at cycle N:
  - `bmem_read` high from N+1 until the first `bmem_ready`.
  - `resp` pulses the cycle after the 4th matching `rvalid`.
- Write, request sampled at N with `bmem_ready` always high: beats at N+1..N+4, `d_resp` at N+5.
- The earliest next grant is the cycle after RESP, so back-to-back transactions have one IDLE cycle between them.

## Structure
- Package `bmem_arb_pkg`: state enum `bmem_arb_state_t`, `grant_t` {GRANT_I, GRANT_D}, and constants `LINE_WIDTH`, `BEAT_IDX_W`, `OFFSET_BITS`=5.
- Sub-module `bmem_line_buffer`: 256-bit shift-in/indexed-write register holding beat index and `done`. Used for read reassembly.
- The FSM and arbitration stay in `bmem_arbiter`.

## Test plan
- Icache read of addr 0x1ECEB01C:
  - `bmem_addr` = 0x1ECEB000 for 1 cycle (ready high).
  - Return beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - `i_rdata` = {0x44..,0x33..,0x22..,0x11..}; exactly one `i_resp`.
- Dcache write of line with beat k = 0xA0+k replicated, `bmem_ready` low on cycles 2–3 of the burst:
  - Each beat is held until accepted; exactly 4 accepted beats; `d_resp` after the last.
- Simultaneous `i_read`/`d_read` after reset: icache served first, then dcache. A second simultaneous pair is then served dcache first.
- Interleaved foreign `rvalid` with `raddr` ≠ latched address during RD_WAIT: ignored; line equals only the matching beats.
- Assert `rst` after 2 read beats: outputs 0 next cycle, no resp. A fresh read afterwards completes correctly.
- Spurious `bmem_rvalid` in IDLE: no state change, no resp, assertion warning logged.

Source files
------------

// File: rtl/bmem_arbiter_pkg.sv
// Shared types and constants for the cache-to-banked-memory arbiter.
// One outstanding line transaction; lines move as fixed-size beat bursts.
package bmem_arb_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BEAT_IDX_W  = 2;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BURST,
    RESP
  } bmem_arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/bmem_arbiter_if.sv
// Cache-side line ports and the banked-memory beat port, bundled for the arbiter.
// master = the arbiter's view; slave = the caches plus banked memory.
interface bmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 4
);
  localparam int LW = BEAT_WIDTH * BEATS;

  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_read;
  logic [LW-1:0]         i_rdata;
  logic                  i_resp;

  logic [ADDR_WIDTH-1:0] d_addr;
  logic                  d_read;
  logic                  d_write;
  logic [LW-1:0]         d_wdata;
  logic [LW-1:0]         d_rdata;
  logic                  d_resp;

  logic [ADDR_WIDTH-1:0] bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BEAT_WIDTH-1:0] bmem_wdata;
  logic                  bmem_ready;
  logic [ADDR_WIDTH-1:0] bmem_raddr;
  logic [BEAT_WIDTH-1:0] bmem_rdata;
  logic                  bmem_rvalid;

  modport master (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output i_rdata, i_resp, d_rdata, d_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  modport slave (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/bmem_arbiter_line_buffer.sv
// Line reassembly register: writes beat `din` at the current beat index, tracks completion.
// Latency: one cycle per accepted beat; the index saturates on the last beat and sets done.
// Backpressure: none; the caller only pulses inc when a beat is actually transferred.
module bmem_line_buffer #(
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 4,
  parameter int IDX_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        inc,
  input  logic                        capture,
  input  logic [BEAT_WIDTH-1:0]       din,
  output logic [BEAT_WIDTH*BEATS-1:0] line,
  output logic [IDX_W-1:0]            beat,
  output logic                        last,
  output logic                        done
);

  assign last = (beat == IDX_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      line <= '0;
      beat <= '0;
      done <= 1'b0;
    end else if (inc) begin
      if (capture) line[beat*BEAT_WIDTH +: BEAT_WIDTH] <= din;
      // The index holds at the final beat so a burst never wraps onto beat 0.
      if (last) done <= 1'b1;
      else      beat <= beat + 1'b1;
    end
  end

endmodule

// File: rtl/bmem_arbiter.sv
// Round-robin merge of icache/dcache line requests onto one beat-wide banked-memory port.
// Latency: grant 1 cycle after request; write = 4 accepted beats + resp; read resp 1 cycle after 4th beat.
// Backpressure: read request and each write beat are held until bmem_ready; one transaction in flight.
module bmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 64,
  parameter int BEATS      = 4
) (
  input  logic           clk,
  input  logic           rst,
  bmem_arbiter_if.master bus
);
  import bmem_arb_pkg::*;

  localparam int LW = BEAT_WIDTH * BEATS;
  localparam int IW = $clog2(BEATS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

  bmem_arb_state_t       state_q, state_d;
  grant_t                grant_q, last_grant_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]         wline_q, i_line_q, d_line_q;

  logic                  i_req, d_req, pick_d, beat_hit;
  logic                  lb_clr, lb_inc, lb_capture, lb_last, lb_done;
  logic [IW-1:0]         lb_beat;
  logic [LW-1:0]         lb_line;

  logic                  bm_read, bm_write, i_resp, d_resp;
  logic [ADDR_WIDTH-1:0] bm_addr;
  logic [BEAT_WIDTH-1:0] bm_wdata;
  logic [LW-1:0]         i_rdata, d_rdata;

  assign i_req    = bus.i_read;
  assign d_req    = bus.d_read | bus.d_write;
  assign pick_d   = d_req && (!i_req || last_grant_q == GRANT_I);
  assign beat_hit = (state_q == RD_WAIT) && bus.bmem_rvalid && (bus.bmem_raddr == addr_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (i_req || d_req) state_d = (pick_d && bus.d_write) ? WR_BURST : RD_REQ;
      RD_REQ:   if (bus.bmem_ready) state_d = RD_WAIT;
      RD_WAIT:  if (beat_hit && lb_last) state_d = RESP;
      WR_BURST: if (bus.bmem_ready && lb_last) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bm_read    = 1'b0;
    bm_write   = 1'b0;
    bm_addr    = '0;
    bm_wdata   = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    i_rdata    = i_line_q;
    d_rdata    = d_line_q;
    lb_clr     = 1'b0;
    lb_inc     = 1'b0;
    lb_capture = 1'b0;
    case (state_q)
      IDLE: lb_clr = 1'b1;
      RD_REQ: begin
        bm_read = 1'b1;
        bm_addr = addr_q;
      end
      RD_WAIT: begin
        lb_inc     = beat_hit;
        lb_capture = 1'b1;
      end
      WR_BURST: begin
        bm_write = 1'b1;
        bm_addr  = addr_q;
        bm_wdata = wline_q[lb_beat*BEAT_WIDTH +: BEAT_WIDTH];
        lb_inc   = bus.bmem_ready;
      end
      RESP: begin
        // The fresh line is visible in the resp cycle, before the per-port register catches it.
        if (grant_q == GRANT_I) begin
          i_resp  = 1'b1;
          i_rdata = lb_line;
        end else begin
          d_resp = 1'b1;
          if (!wr_q) d_rdata = lb_line;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= GRANT_I;
      last_grant_q <= GRANT_D;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wline_q      <= '0;
      i_line_q     <= '0;
      d_line_q     <= '0;
    end else begin
      if (state_q == IDLE && (i_req || d_req)) begin
        grant_q <= pick_d ? GRANT_D : GRANT_I;
        wr_q    <= pick_d && bus.d_write;
        addr_q  <= (pick_d ? bus.d_addr : bus.i_addr) & ALIGN_MASK;
        // Snapshot the writeback line so bmem_wdata never depends combinationally on d_wdata.
        if (pick_d && bus.d_write) wline_q <= bus.d_wdata;
      end
      if (state_q == RESP) begin
        last_grant_q <= grant_q;
        if (grant_q == GRANT_I) i_line_q <= lb_line;
        else if (!wr_q)         d_line_q <= lb_line;
      end
    end
  end

  bmem_line_buffer #(
    .BEAT_WIDTH(BEAT_WIDTH),
    .BEATS     (BEATS),
    .IDX_W     (IW)
  ) u_line_buffer (
    .clk    (clk),
    .rst    (rst),
    .clr    (lb_clr),
    .inc    (lb_inc),
    .capture(lb_capture),
    .din    (bus.bmem_rdata),
    .line   (lb_line),
    .beat   (lb_beat),
    .last   (lb_last),
    .done   (lb_done)
  );

  assign bus.bmem_read  = bm_read;
  assign bus.bmem_write = bm_write;
  assign bus.bmem_addr  = bm_addr;
  assign bus.bmem_wdata = bm_wdata;
  assign bus.i_resp     = i_resp;
  assign bus.d_resp     = d_resp;
  assign bus.i_rdata    = i_rdata;
  assign bus.d_rdata    = d_rdata;

  a_d_rw_excl: assert property (@(posedge clk) disable iff (rst) !(bus.d_read && bus.d_write))
    else $error("dcache read and write requested together");
  a_i_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q != IDLE && grant_q == GRANT_I) |-> (bus.i_read && $stable(bus.i_addr)))
    else $error("icache request changed before resp");
  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q != IDLE && grant_q == GRANT_D) |-> ((wr_q ? bus.d_write : bus.d_read) && $stable(bus.d_addr)))
    else $error("dcache request changed before resp");
  a_rvalid_window: assert property (@(posedge clk) disable iff (rst) bus.bmem_rvalid |-> state_q == RD_WAIT)
    else $warning("bmem_rvalid outside RD_WAIT ignored");
  a_resp_done: assert property (@(posedge clk) disable iff (rst) (state_q == RESP) |-> lb_done)
    else $error("resp without a complete burst");

endmodule

// File: tb/tb_bmem_arbiter.sv
// Bench for bmem_arbiter: reset, arbitration table, directed corner sequences, random traffic vs a line-level model.
module tb_bmem_arbiter;
  localparam int AW = 32;
  localparam int BW = 64;
  localparam int NB = 4;
  localparam int LW = BW * NB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bmem_arbiter_if #(.ADDR_WIDTH(AW), .BEAT_WIDTH(BW), .BEATS(NB)) bus ();

  bmem_arbiter #(.ADDR_WIDTH(AW), .BEAT_WIDTH(BW), .BEATS(NB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [LW-1:0] mem [logic [AW-1:0]];

  typedef struct {
    logic ir, dr, dw;
    logic exp_d, exp_wr;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    if (mem.exists(a)) return mem[a];
    for (int k = 0; k < NB; k++) l[k*BW +: BW] = {a, 32'hB0B0_0000 | 32'(k)};
    return l;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full line transaction with a bench-side banked memory; expects the given grant and op.
  task automatic run_txn(input logic ir, input logic dr, input logic dw,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da, input logic [LW-1:0] wd,
                         input logic [15:0] stall, input bit noisy, input bit exp_d, input bit exp_wr,
                         input string tag, output int cyc, output int rd_cyc);
    logic [AW-1:0] ea;
    logic [LW-1:0] eline;
    int beats, sent;
    bit acc, got, fb, gap;
    ea = align(exp_d ? da : ia);
    eline = mem_line(ea);
    beats = 0; sent = 0; acc = 0; got = 0; fb = 0; rd_cyc = 0; cyc = -1;
    bus.i_read = ir; bus.i_addr = ia;
    bus.d_read = dr; bus.d_write = dw; bus.d_addr = da; bus.d_wdata = wd;
    tick;
    chk({tag, "_first_rd"}, bus.bmem_read, !exp_wr);
    chk({tag, "_first_wr"}, bus.bmem_write, exp_wr);
    for (int c = 0; c < 200; c++) begin
      bus.bmem_rvalid = 1'b0;
      bus.bmem_ready  = 1'b0;
      if (bus.i_resp || bus.d_resp) begin
        cyc = c; got = 1;
        chk({tag, "_resp_port"}, bus.d_resp, exp_d);
        chk({tag, "_resp_both"}, bus.i_resp & bus.d_resp, 0);
        if (exp_wr) chk({tag, "_beats"}, beats, NB);
        else chk({tag, "_rdata"}, exp_d ? bus.d_rdata : bus.i_rdata, eline);
        break;
      end
      if (bus.bmem_read || bus.bmem_write) chk({tag, "_addr"}, bus.bmem_addr, ea);
      if (bus.bmem_write) begin
        chk({tag, "_wbeat"}, bus.bmem_wdata, wd[(beats % NB)*BW +: BW]);
        bus.bmem_ready = !stall[c % 16];
        if (bus.bmem_ready) beats++;
      end else if (bus.bmem_read) begin
        rd_cyc++;
        bus.bmem_ready = !stall[c % 16];
        if (bus.bmem_ready) acc = 1;
      end else if (acc && sent < NB) begin
        gap = noisy && ($urandom_range(0, 3) == 0);
        if (!gap) begin
          bus.bmem_rvalid = 1'b1;
          if (noisy && !fb) begin
            bus.bmem_raddr = ea ^ 32'h0000_0100;
            bus.bmem_rdata = {$urandom(), $urandom()};
            fb = 1;
          end else begin
            bus.bmem_raddr = ea;
            bus.bmem_rdata = eline[sent*BW +: BW];
            sent++;
            fb = 0;
          end
        end
      end
      tick;
    end
    chk({tag, "_resp_seen"}, got, 1);
    if (exp_wr) mem[ea] = wd;
    tick;
    chk({tag, "_pulse_len"}, bus.i_resp | bus.d_resp, 0);
    if (!exp_wr) chk({tag, "_rdata_hold"}, exp_d ? bus.d_rdata : bus.i_rdata, eline);
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] wd, line_a;
    logic [AW-1:0] ia, da;
    int cyc, rdc, pat;
    bit ir, dr, dw, ed, ew, last_d, noisy;
    logic [15:0] stall;

    rst = 1'b1;
    bus.i_read = 0; bus.i_addr = '0; bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.bmem_ready = 0; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 0;
    tick; tick;
    chk("rst_bmem_read", bus.bmem_read, 0);
    chk("rst_bmem_write", bus.bmem_write, 0);
    chk("rst_bmem_addr", bus.bmem_addr, 0);
    chk("rst_bmem_wdata", bus.bmem_wdata, 0);
    chk("rst_i_resp", bus.i_resp, 0);
    chk("rst_d_resp", bus.d_resp, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    rst = 1'b0;
    tick;

    // Arbitration table: first tie after reset goes to icache, then alternates.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int n = 0; n < 8; n++) begin
      ia = 32'h1000_0007 + 32'(n) * 32'h40;
      da = 32'h2000_0003 + 32'(n) * 32'h40;
      wd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      run_txn(tbl[n].ir, tbl[n].dr, tbl[n].dw, ia, da, wd, (n % 2 == 1) ? 16'h0002 : 16'h0000,
              n >= 4, tbl[n].exp_d, tbl[n].exp_wr, $sformatf("tbl%0d", n), cyc, rdc);
    end

    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    mem[32'h1ECE_B000] = line_a;
    run_txn(1, 0, 0, 32'h1ECE_B01C, '0, '0, 16'h0000, 0, 0, 0, "icache_rd", cyc, rdc);
    chk("icache_rd_req_cycles", rdc, 1);
    chk("icache_rd_resp_cycle", cyc, 5);
    chk("icache_rd_line", bus.i_rdata, line_a);

    for (int k = 0; k < NB; k++) wd[k*BW +: BW] = {8{8'(8'hA0 + k)}};
    run_txn(0, 0, 1, '0, 32'h0000_3000, wd, 16'h0006, 0, 1, 1, "dcache_wr", cyc, rdc);
    chk("dcache_wr_resp_cycle", cyc, 6);

    // Stray read beats while idle must be ignored.
    bus.bmem_rvalid = 1'b1; bus.bmem_raddr = 32'h0000_3000; bus.bmem_rdata = 64'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("spurious_no_req", bus.bmem_read | bus.bmem_write, 0);
      chk("spurious_no_resp", bus.i_resp | bus.d_resp, 0);
    end
    bus.bmem_rvalid = 1'b0;
    tick;

    // Reset in the middle of a read burst, two beats in.
    line_a = mem_line(32'h0000_5000);
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_5000;
    tick;
    bus.bmem_ready = 1'b1;
    tick;
    bus.bmem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.bmem_rvalid = 1'b1; bus.bmem_raddr = 32'h0000_5000; bus.bmem_rdata = line_a[k*BW +: BW];
      tick;
    end
    bus.bmem_rvalid = 1'b0; bus.i_read = 1'b0; rst = 1'b1;
    tick;
    chk("midrst_bmem_read", bus.bmem_read, 0);
    chk("midrst_bmem_addr", bus.bmem_addr, 0);
    chk("midrst_i_resp", bus.i_resp, 0);
    chk("midrst_i_rdata", bus.i_rdata, 0);
    chk("midrst_d_rdata", bus.d_rdata, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("midrst_no_resp", bus.i_resp | bus.d_resp, 0);
    end
    run_txn(1, 1, 0, 32'h0000_5000, 32'h0000_6000, '0, 16'h0000, 1, 0, 0, "tie_after_rst", cyc, rdc);

    // Random traffic against a line-level model: round-robin on ties, memory as an array of lines.
    last_d = 1'b0;
    for (int n = 0; n < 40; n++) begin
      pat = $urandom_range(0, 4);
      ir = (pat == 0) || (pat >= 3);
      dr = (pat == 1) || (pat == 3);
      dw = (pat == 2) || (pat == 4);
      ed = (ir && (dr || dw)) ? !last_d : (dr || dw);
      ew = ed && dw;
      last_d = ed;
      ia = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      da = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      wd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      stall = 16'($urandom() & $urandom()) & 16'hFFFE;
      noisy = 1'($urandom_range(0, 1));
      run_txn(ir, dr, dw, ia, da, wd, stall, noisy, ed, ew, $sformatf("rnd%0d", n), cyc, rdc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
